// File: rtl/aes_ct_collector.sv
// aes_ct_collector: reassembles the AES core's byte-serial ciphertext into
// 128-bit blocks, queues them in a small first-word-fall-through FIFO and
// hands them to the host over valid/ready. A block that completes while the
// FIFO is full and not draining is dropped, and a sticky overflow flag is raised.
//
// Optional build macro AES_CT_MSB_FIRST_EN: when defined, the first byte of a
// block lands in the most significant byte. The default placement is LSB first.
module aes_ct_collector #(
    parameter int DEPTH = 2,    // FIFO entries, power of two in 2..8
    parameter int CNT_W = 16    // completed-block counter width
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [7:0]         ct_byte_i,
    input  logic               ct_valid_i,
    input  logic               flush_i,
    input  logic               clr_ovf_i,
    output logic [127:0]       blk_data_o,
    output logic               blk_valid_o,
    input  logic               blk_ready_i,
    output logic               busy_o,
    output logic               overflow_o,
    output logic [CNT_W-1:0]   blk_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    state_e             state_q;
    logic [3:0]         byte_cnt_q;
    // Only 15 byte lanes are stored: the 16th byte goes straight into the FIFO.
    logic [119:0]       asm_q;
    logic [127:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [OCC_W-1:0]   occ_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               last_byte;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push;
    logic               drop;
    logic [3:0]         lane_sel;
    logic [127:0]       commit_word;

    // Handshake and commit decisions for the current cycle
    always_comb begin
        accept     = ct_valid_i & ~flush_i;
        last_byte  = accept & (byte_cnt_q == 4'hF);
        fifo_empty = (occ_q == '0);
        fifo_full  = (occ_q == OCC_W'(DEPTH));
        pop        = ~fifo_empty & blk_ready_i;
        push       = last_byte & (~fifo_full | pop);
        drop       = last_byte & fifo_full & ~pop;
`ifdef AES_CT_MSB_FIRST_EN
        // asm_q holds block bits [127:8]; byte k belongs in lane 14-k.
        lane_sel    = 4'd14 - byte_cnt_q;
        commit_word = {asm_q, ct_byte_i};
`else
        // asm_q holds block bits [119:0]; byte k belongs in lane k.
        lane_sel    = byte_cnt_q;
        commit_word = {ct_byte_i, asm_q};
`endif
    end

    // Byte counter and IDLE/COLLECT state; flush beats an incoming byte
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            byte_cnt_q <= 4'd0;
        end else if (flush_i) begin
            state_q    <= IDLE;
            byte_cnt_q <= 4'd0;
        end else if (ct_valid_i) begin
            byte_cnt_q <= byte_cnt_q + 4'd1;
            state_q    <= (byte_cnt_q == 4'hF) ? IDLE : COLLECT;
        end
    end

    // One byte lane per stored assembly byte; the 16th byte never hits a lane
    generate
        for (genvar gi = 0; gi < 15; gi++) begin : g_lane
            // Capture the arriving byte when it targets this lane
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    asm_q[8*gi +: 8] <= 8'h00;
                end else if (accept && lane_sel == 4'(gi)) begin
                    asm_q[8*gi +: 8] <= ct_byte_i;
                end
            end
        end
    endgenerate

    // FIFO storage entries, written at the write pointer on a push
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Store the completed block into this entry when it is the tail
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    mem_q[gi] <= '0;
                end else if (push && wr_ptr_q == PTR_W'(gi)) begin
                    mem_q[gi] <= commit_word;
                end
            end
        end
    endgenerate

    // FIFO pointers and occupancy; push+pop together leaves occupancy unchanged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      occ_q <= occ_q + OCC_W'(1);
            else if (pop && !push) occ_q <= occ_q - OCC_W'(1);
        end
    end

    // Sticky overflow (a drop wins over a clear) and the pushed-block counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (drop)           ovf_q <= 1'b1;
            else if (clr_ovf_i) ovf_q <= 1'b0;
            if (push)           cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign blk_data_o  = mem_q[rd_ptr_q];
    assign blk_valid_o = ~fifo_empty;
    assign busy_o      = (state_q == COLLECT);
    assign overflow_o  = ovf_q;
    assign blk_count_o = cnt_q;

endmodule

// File: doc/aes_ct_collector.md
Name: aes_ct_collector

Overview:
- Downstream of the AES encryption core. Consumes the core's byte-serial ciphertext stream (state_out_byte qualified by ready) and reassembles each 16-byte burst into a 128-bit block.
- Completed blocks are buffered in a small FIFO and presented to the host over a valid/ready handshake, with overflow detection and a block counter.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, 2..8.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low; assertion clears all state immediately.
- ct_byte  in  8  ciphertext byte from the encryption core.
- ct_valid  in  1  core's ready output. Every cycle it is high carries one new byte. Bytes arrive least-significant byte first.
- flush  in  1  discards any partially assembled block.
- clr_ovf  in  1  clears the sticky overflow flag.
- blk_data  out  128  head-of-FIFO ciphertext block.
- blk_valid  out  1  FIFO not empty.
- blk_ready  in  1  host accepts the head block when blk_valid and blk_ready are both high.
- busy  out  1  partial block in progress (byte_cnt != 0).
- overflow  out  1  sticky; set when a completed block was dropped.
- blk_count  out  CNT_W  number of blocks pushed into the FIFO; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: blk_data=0, blk_valid=0, busy=0, overflow=0, blk_count=0. Internally: byte_cnt=0, FIFO empty, assembly register=0, FSM=IDLE.
- FSM states: IDLE (byte_cnt=0) and COLLECT (1..15 bytes held).
  - IDLE -> COLLECT on ct_valid.
  - COLLECT -> IDLE on the 16th byte or on flush.
- Byte placement: the k-th byte (k=0..15) is written to bits [8k+7:8k]. byte_cnt is 4 bits and wraps 15 -> 0 on the 16th byte.
- Commit: on the edge sampling the 16th byte, {ct_byte, assembly[119:0]} is written directly into the FIFO. blk_valid rises the following cycle if the FIFO was empty, so latency is 1 cycle from the 16th byte to blk_valid. The assembly register need not be cleared.
- Back-to-back: a new byte 0 on the cycle after the 16th byte is accepted normally, so no bubble is required.
- FIFO is registered with first-word fall-through; blk_data is always the head entry.
  - Pop occurs on blk_valid & blk_ready.
  - Push and pop in the same cycle are both legal, including when full; occupancy is then unchanged.
  - blk_data holds its value while blk_valid=1 and blk_ready=0.
- Overflow: if the FIFO is full and not popping when a block completes, that block is dropped, overflow is set, and blk_count does not increment.
  - clr_ovf clears overflow.
  - A simultaneous set and clear leaves overflow set.
- blk_count increments exactly once per successful push.
- flush: clears byte_cnt and returns the FSM to IDLE. A ct_valid byte in the same cycle is discarded, because flush has priority. The FIFO, blk_count and overflow are unaffected.
- Gaps: ct_valid may deassert mid-block; the partial block is held indefinitely.
- Reset mid-block or mid-handshake: everything is lost immediately, and outputs return to their reset values asynchronously.
- ct_valid is never back-pressured. The upstream core has no stall input, so loss is reported only via overflow.

Optional Feature:
- Macro: AES_CT_MSB_FIRST_EN.
- Defined: byte k is placed at bits [127-8k:120-8k] (first byte is MSB). The commit word is {assembly[127:8], ct_byte}.
- Undefined: LSB-first placement as described above.
- Handshake, latency and counters are identical in both modes.

Test Plan:
- Single block: after reset, send 16 consecutive ct_valid bytes 32,0b,6a,19,97,85,11,dc,fb,09,dc,02,1d,84,25,39 with blk_ready=1 -> blk_valid pulses 1 cycle, one cycle after the last byte. blk_data=3925841d02dc09fbdc118597196a0b32. blk_count=1.
- Back-to-back with stall: 3 blocks of 16 bytes each with no gaps, blk_ready=0, DEPTH=2 -> first two blocks queued in order, third dropped. overflow=1, blk_count=2. Raising blk_ready then pops exactly 2 blocks. Pulsing clr_ovf then gives overflow=0.
- Full and simultaneous: with the FIFO full, hold blk_ready=1 on the cycle the next block completes -> no drop, overflow stays 0, blk_count increments, occupancy remains 2.
- Flush: send 7 bytes, then flush together with an 8th byte -> busy=0 and the 8th byte is ignored. A following clean 16-byte block assembles correctly.
- Gaps and async reset: 16 bytes with ct_valid toggling every other cycle -> correct block. Asserting rst low after byte 9 of a new block, between clock edges -> busy, blk_valid and blk_count are 0 immediately, with no stray block after release.
- Macro: build with AES_CT_MSB_FIRST_EN, send the same stimulus as the single-block test -> blk_data=320b6a199785 11dcfb09dc021d842539 (bytes in arrival order, first byte at MSB).
